// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : shared AES-128 types, S-box/rcon tables, GF(2^8) xtime helper.
// Rev 1.0
// ============================================================================
package aes_pkg;

  typedef logic [0:127] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_t;

  // Entry b lives at bits [8b : 8b+7]
  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:79] RCON_TABLE = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{b, 3'b000} +: 8];
  endfunction

  // Round numbers 1..10 map to table entries 0..9
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [3:0] idx;
    idx = rnd - 4'd1;
    if (rnd == 4'd0 || rnd > 4'd10) return 8'h00;
    return RCON_TABLE[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// aes_sbox : combinational AES forward S-box byte lookup.
// Rev 1.0
// ============================================================================
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = sbox(din);

endmodule
`default_nettype wire

// File: rtl/aes128_encrypt_iter.sv
`default_nettype none
// ============================================================================
// aes128_encrypt_iter : iterative AES-128 encryptor, one round per clock with
// on-the-fly key expansion. Define AES_ENC_LAST_KEY_EN to expose last_key.
// Rev 1.0
// ============================================================================
module aes128_encrypt_iter
  import aes_pkg::*;
#(
  parameter int unsigned NR    = 10,
  parameter bit          SCRUB = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] plaintext,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ciphertext,
  output logic         busy
`ifdef AES_ENC_LAST_KEY_EN
  ,
  output logic [0:127] last_key
`endif
);

  if (NR != 10) begin : g_nr_check
    $error("aes128_encrypt_iter: NR must be 10");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  aes_fsm_t   fsm_q, fsm_d;
  logic [3:0] round_q;
  aes_state_t state_q, rkey_q;
  aes_state_t next_state, next_key;

  logic [7:0] sb [16];
  logic [7:0] kt [4];
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  logic [7:0] nk [16];
  logic [7:0] tw [4];

  for (genvar k = 0; k < 16; k++) begin : g_state_sbox
    aes_sbox u_sbox (.din(state_q[8*k +: 8]), .dout(sb[k]));
  end

  // RotWord folded into the wiring: output row r takes column-3 byte of row r+1
  for (genvar r = 0; r < 4; r++) begin : g_key_sbox
    aes_sbox u_sbox (.din(rkey_q[8*(4*((r+1)%4)+3) +: 8]), .dout(kt[r]));
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sr[4*r+c] = sb[4*r+((c+r)%4)];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[c]    = xtime(sr[c]) ^ xtime(sr[4+c]) ^ sr[4+c] ^ sr[8+c] ^ sr[12+c];
      mc[4+c]  = sr[c] ^ xtime(sr[4+c]) ^ xtime(sr[8+c]) ^ sr[8+c] ^ sr[12+c];
      mc[8+c]  = sr[c] ^ sr[4+c] ^ xtime(sr[8+c]) ^ xtime(sr[12+c]) ^ sr[12+c];
      mc[12+c] = xtime(sr[c]) ^ sr[c] ^ sr[4+c] ^ sr[8+c] ^ xtime(sr[12+c]);
    end
    for (int r = 0; r < 4; r++) begin
      tw[r] = kt[r];
    end
    tw[0] = kt[0] ^ rcon(round_q);
    for (int r = 0; r < 4; r++) begin
      nk[4*r] = rkey_q[8*(4*r) +: 8] ^ tw[r];
      for (int c = 1; c < 4; c++) begin
        nk[4*r+c] = rkey_q[8*(4*r+c) +: 8] ^ nk[4*r+c-1];
      end
    end
    next_state = '0;
    next_key   = '0;
    for (int k = 0; k < 16; k++) begin
      next_key[8*k +: 8]   = nk[k];
      next_state[8*k +: 8] = ((round_q == LAST_ROUND) ? sr[k] : mc[k]) ^ nk[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      ST_IDLE: if (in_valid)                fsm_d = ST_RUN;
      ST_RUN:  if (round_q == LAST_ROUND)   fsm_d = ST_DONE;
      ST_DONE: if (out_ready)               fsm_d = ST_IDLE;
      default:                              fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_q    <= '0;
      state_q    <= '0;
      rkey_q     <= '0;
      ciphertext <= '0;
`ifdef AES_ENC_LAST_KEY_EN
      last_key   <= '0;
`endif
    end else begin
      unique case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q <= plaintext ^ key;
            rkey_q  <= key;
            round_q <= 4'd1;
          end
        end
        ST_RUN: begin
          state_q <= next_state;
          rkey_q  <= next_key;
          if (round_q == LAST_ROUND) begin
            ciphertext <= next_state;
`ifdef AES_ENC_LAST_KEY_EN
            last_key   <= next_key;
`endif
            round_q    <= '0;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        ST_DONE: begin
          // Ciphertext survives the scrub; only working state is cleared
          if (out_ready && SCRUB) begin
            state_q <= '0;
            rkey_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (fsm_q == ST_IDLE);
  assign out_valid = (fsm_q == ST_DONE);
  assign busy      = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_aes128_encrypt_iter.sv
`default_nettype none
// ============================================================================
// tb_aes128_encrypt_iter : scoreboard bench with an algebraic AES-128 reference.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [0:127] plaintext = '0;
  logic [0:127] key = '0;
  logic         in_ready, out_valid, busy;
  logic [0:127] ciphertext;
`ifdef AES_ENC_LAST_KEY_EN
  logic [0:127] last_key;
`endif

  aes128_encrypt_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .plaintext(plaintext), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .ciphertext(ciphertext), .busy(busy)
`ifdef AES_ENC_LAST_KEY_EN
    , .last_key(last_key)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [0:127] ct;
    logic [0:127] lk;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  bit ready_rand = 1'b0;
  logic [7:0] tb_sbox [256];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic abort(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "bench aborted");
  endtask

  // ---------------- reference model: S-box derived from GF(2^8) algebra ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    if (a == 8'h00) inv = 8'h00;
    else for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  function automatic void aes_ref(input logic [0:127] p, input logic [0:127] k,
                                  output logic [0:127] ct, output logic [0:127] lk);
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] w [44][4];
    logic [7:0] tmp [4];
    logic [7:0] rc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s[r][c] = p[8*(4*r+c) +: 8];
        w[c][r] = k[8*(4*r+c) +: 8];
      end
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int r = 0; r < 4; r++) tmp[r] = w[i-1][r];
      if (i % 4 == 0) begin
        for (int r = 0; r < 4; r++) tmp[r] = tb_sbox[w[i-1][(r+1)%4]];
        tmp[0] = tmp[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      for (int r = 0; r < 4; r++) w[i][r] = w[i-4][r] ^ tmp[r];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[c][r];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = tb_sbox[s[r][(c+r)%4]];
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          s[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
          s[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd+c][r];
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ct[8*(4*r+c) +: 8] = s[r][c];
        lk[8*(4*r+c) +: 8] = w[40+c][r];
      end
  endfunction

  // ---------------- stimulus ----------------
  task automatic send(input logic [0:127] p, input logic [0:127] k,
                      input logic [0:127] ect, input logic [0:127] elk, output int acc);
    exp_t e;
    int w;
    plaintext = p;
    key       = k;
    in_valid  = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 300) abort("accept_wait");
    end
    @(posedge clk);
    #1;
    acc   = cyc;
    e.ct  = ect;
    e.lk  = elk;
    e.acc = acc;
    exp_q.push_back(e);
  endtask

  task automatic send_rand(output int acc);
    logic [0:127] p, k, ct, lk;
    p = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    aes_ref(p, k, ct, lk);
    send(p, k, ct, lk, acc);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor / scoreboard ----------------
  bit prev_ov = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 128'(out_valid), 128'd0);
        end else begin
          if (!prev_ov) chk("latency", 128'(cyc - exp_q[0].acc), 128'd10);
          chk("ciphertext", ciphertext, exp_q[0].ct);
`ifdef AES_ENC_LAST_KEY_EN
          chk("last_key", last_key, exp_q[0].lk);
`endif
          chk("in_ready_in_done", 128'(in_ready), 128'd0);
          chk("busy_in_done", 128'(busy), 128'd1);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  localparam logic [0:127] FIPS_PT = 128'h004488cc115599dd2266aaee3377bbff;
  localparam logic [0:127] FIPS_KY = 128'h0004080c0105090d02060a0e03070b0f;
  localparam logic [0:127] FIPS_CT = 128'h696ad870c47bcdb4e004b7c5d830805a;
  localparam logic [0:127] FIPS_LK = 128'h13e3f34d1194072b1d4aa7307f178bc5;
  localparam logic [0:127] ZERO_CT = 128'h66ef88cae98a4c344b2cfa2bd43b592e;

  initial begin
    int a0, a1, a2, w;
    logic [0:127] ct, lk;
    for (int i = 0; i < 256; i++) tb_sbox[i] = affine_inv(8'(i));

    #12;
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_ciphertext", ciphertext, 128'd0);
    #10 rst = 1'b0;
    #1;
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;

    // FIPS-197 vector and all-zero vector
    out_ready = 1'b1;
    send(FIPS_PT, FIPS_KY, FIPS_CT, FIPS_LK, a0);
    in_valid = 1'b0;
    drain();
    aes_ref('0, '0, ct, lk);
    send('0, '0, ZERO_CT, lk, a0);
    in_valid = 1'b0;
    drain();

    // Backpressure: hold out_ready low while a second block is offered
    out_ready = 1'b0;
    send_rand(a0);
    fork
      send_rand(a1);
      begin
        w = 0;
        while (!out_valid && w < 50) begin
          @(negedge clk);
          w++;
        end
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    chk("backpressure_accept_gap", 128'(a1 - a0), 128'd18);
    drain();

    // Back-to-back with in_valid held high
    send_rand(a0);
    send_rand(a1);
    send_rand(a2);
    in_valid = 1'b0;
    chk("b2b_period_1", 128'(a1 - a0), 128'd12);
    chk("b2b_period_2", 128'(a2 - a1), 128'd12);
    drain();

    // Reset in the middle of a block
    send(FIPS_PT, FIPS_KY, FIPS_CT, FIPS_LK, a0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    #4 rst = 1'b0;
    #1;
    chk("midrun_rst_out_valid", 128'(out_valid), 128'd0);
    chk("midrun_rst_ciphertext", ciphertext, 128'd0);
    chk("midrun_rst_in_ready", 128'(in_ready), 128'd1);
    chk("midrun_rst_busy", 128'(busy), 128'd0);
    @(posedge clk);
    #1;
    send(FIPS_PT, FIPS_KY, FIPS_CT, FIPS_LK, a0);
    in_valid = 1'b0;
    drain();

    // Randomized blocks with random output backpressure
    ready_rand = 1'b1;
    for (int n = 0; n < 20; n++) begin
      send_rand(a0);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(posedge clk);
      #1;
    end
    drain();
    ready_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    abort("global_timeout");
  end

endmodule
`default_nettype wire
